mem_port_arbiter: RTL and testbench

- Shares one mem_system instance (16-bit addr/data, Rd/Wr in; DataOut/Done/Stall/err out) between an instruction-fetch requester (read-only) and a data requester (read/write).
- Sits between the pipeline's fetch and memory stages and the unified cache/memory system.
- Sequences one transaction at a time, holds the address and data stable until Done, and routes the response back.
- Arbitrates round-robin on conflict and flags hung transactions with a watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    WAIT_I  = 3'd2,
    ISSUE_D = 3'd3,
    WAIT_D  = 3'd4
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Round-robin pick: data wins when it is the only requester, or when both
  // request and fetch was the side granted last.
  function automatic logic grant_to_d(input logic i_pend, input logic d_pend,
                                      input logic last_grant);
    return d_pend & (~i_pend | (last_grant == GNT_I));
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter that flags a transaction waiting TIMEOUT cycles for mem_done.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_o = (cnt_q == CNT_W'(TIMEOUT));

  // Clear on issue, count while waiting, hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !timeout_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory system between a read-only fetch port and a read/write
// data port. One transaction in flight at a time; round-robin on conflict.
// Requesters hold x_rd/x_wr high until x_done pulses for one cycle; x_done is
// the only acceptance, and a request sampled in IDLE is latched so that the
// memory side sees addr/data stable from issue until mem_done.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_datain,
  input  logic              d_rd,
  input  logic              d_wr,
  output logic [DATA_W-1:0] i_dataout,
  output logic              i_done,
  output logic              i_stall,
  output logic [DATA_W-1:0] d_dataout,
  output logic              d_done,
  output logic              d_stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] addr_q, addr_d, data_q, data_d;
  logic              wr_q, wr_d, err_q, err_d;
  logic              wd_clr, wd_en, wd_timeout;
  logic              busy, live, d_pend, d_illegal, grant_d, grant_i;
  logic              mem_rd_c, mem_wr_c, i_done_c, d_done_c;
  logic [DATA_W-1:0] i_data_c, d_data_c;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .timeout_o (wd_timeout)
  );

  assign d_pend    = d_rd ^ d_wr;
  assign d_illegal = d_rd & d_wr;
  assign grant_d   = grant_to_d(i_rd, d_pend, last_grant_q);
  assign grant_i   = i_rd & ~grant_d;
  assign busy      = (state_q != IDLE);
  // Outputs that depend on live request inputs are forced low while in reset.
  assign live      = ~rst;

  // Next-state, latch update and per-state output decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = wr_q;
    err_d        = err_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;
    i_done_c     = 1'b0;
    d_done_c     = 1'b0;
    i_data_c     = '0;
    d_data_c     = '0;
    case (state_q)
      IDLE: begin
        if (d_illegal) begin
          // Read+write together is rejected without touching memory.
          err_d    = 1'b1;
          d_done_c = 1'b1;
        end else if (grant_i) begin
          state_d      = ISSUE_I;
          last_grant_d = GNT_I;
          addr_d       = i_addr;
          data_d       = '0;
          wr_d         = 1'b0;
        end else if (grant_d) begin
          state_d      = ISSUE_D;
          last_grant_d = GNT_D;
          addr_d       = d_addr;
          data_d       = d_wr ? d_datain : '0;
          wr_d         = d_wr;
        end
      end
      ISSUE_I: begin
        mem_rd_c = 1'b1;
        wd_clr   = 1'b1;
        state_d  = WAIT_I;
        if (mem_err) err_d = 1'b1;
      end
      ISSUE_D: begin
        mem_rd_c = ~wr_q;
        mem_wr_c = wr_q;
        wd_clr   = 1'b1;
        state_d  = WAIT_D;
        if (mem_err) err_d = 1'b1;
      end
      WAIT_I: begin
        wd_en = 1'b1;
        if (mem_err) err_d = 1'b1;
        if (mem_done) begin
          i_done_c = 1'b1;
          i_data_c = mem_dataout;
          state_d  = IDLE;
        end else if (wd_timeout) begin
          err_d    = 1'b1;
          i_done_c = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT_D: begin
        wd_en = 1'b1;
        if (mem_err) err_d = 1'b1;
        if (mem_done) begin
          d_done_c = 1'b1;
          d_data_c = mem_dataout;
          state_d  = IDLE;
        end else if (wd_timeout) begin
          err_d    = 1'b1;
          d_done_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant history, transaction latches and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
    end
  end

  assign mem_addr   = busy ? addr_q : '0;
  assign mem_datain = busy ? data_q : '0;
  assign mem_rd     = live & mem_rd_c;
  assign mem_wr     = live & mem_wr_c;
  assign i_done     = live & i_done_c;
  assign d_done     = live & d_done_c;
  assign i_dataout  = live ? i_data_c : '0;
  assign d_dataout  = live ? d_data_c : '0;
  assign i_stall    = live & i_rd & ~i_done_c;
  assign d_stall    = live & (d_rd | d_wr) & ~d_done_c;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory responder.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, d_addr, d_datain, mem_dataout;
  logic        i_rd, d_rd, d_wr, mem_done, mem_err;
  logic [15:0] i_dataout, d_dataout, mem_addr, mem_datain;
  logic        i_done, i_stall, d_done, d_stall, mem_rd, mem_wr, err;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  logic        log_wr[$];
  int          log_cyc[$];
  int          resp_lat = 1;
  logic        resp_hang = 1'b0;
  logic        resp_busy;

  wire [70:0] all_outs = {mem_addr, mem_datain, i_dataout, d_dataout,
                          mem_rd, mem_wr, i_done, d_done, i_stall, d_stall, err};

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd),
    .d_addr(d_addr), .d_datain(d_datain), .d_rd(d_rd), .d_wr(d_wr),
    .i_dataout(i_dataout), .i_done(i_done), .i_stall(i_stall),
    .d_dataout(d_dataout), .d_done(d_done), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_err(mem_err), .err(err)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue log: every cycle the DUT drives mem_rd/mem_wr.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_datain);
      log_wr.push_back(mem_wr);
      log_cyc.push_back(cyc);
    end
  end

  // Memory responder: answers resp_lat cycles after issue with addr ^ 16'hA5A5.
  initial begin : responder
    logic [15:0] raddr;
    mem_done = 1'b0;
    mem_dataout = '0;
    resp_busy = 1'b0;
    forever begin
      @(negedge clk);
      if ((mem_rd || mem_wr) && !resp_hang) begin
        resp_busy = 1'b1;
        raddr = mem_addr;
        repeat (resp_lat) @(posedge clk);
        #1;
        mem_done = 1'b1;
        mem_dataout = raddr ^ 16'hA5A5;
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        mem_dataout = '0;
        resp_busy = 1'b0;
      end
    end
  end

  // Global guard.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "hang");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_err = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sample();
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected 0", all_outs);
    end
    i_rd = 1'b1; d_wr = 1'b1; d_rd = 1'b1;
    sample();
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_with_req: got %h expected 0", all_outs);
    end
    i_rd = 1'b0; d_wr = 1'b0; d_rd = 1'b0;
    tick();
    rst = 1'b0;
    sample();
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL after_reset: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_lone_fetch();
    int n0, issue_c, done_c;
    bit done;
    logic [15:0] e;
    resp_lat = 3;
    n0 = log_addr.size();
    issue_c = -1; done_c = -1; done = 0;
    tick();
    i_rd = 1'b1; i_addr = 16'h0040;
    exp_q.push_back(16'h0040 ^ 16'hA5A5);
    for (int k = 0; k < 20 && !done; k++) begin
      sample();
      if (mem_rd && issue_c < 0) issue_c = cyc;
      if (issue_c >= 0) begin
        vectors++;
        if (mem_addr !== 16'h0040) begin
          miscompares++;
          $display("FAIL lone_addr: got %h expected 0040", mem_addr);
        end
      end
      if (i_done) begin
        done = 1; done_c = cyc;
        e = exp_q.pop_front();
        vectors++;
        if (i_dataout !== e) begin
          miscompares++;
          $display("FAIL lone_data: got %h expected %h", i_dataout, e);
        end
      end else begin
        vectors++;
        if (i_stall !== 1'b1 || i_dataout !== 16'h0) begin
          miscompares++;
          $display("FAIL lone_stall: stall %b data %h expected 1 0000", i_stall, i_dataout);
        end
      end
    end
    vectors++;
    if (!done || (done_c - issue_c) != 3) begin
      miscompares++;
      $display("FAIL lone_latency: done %0d latency %0d expected 3", done, done_c - issue_c);
    end
    vectors++;
    if (log_addr.size() != n0 + 1 || log_wr[n0] !== 1'b0 || log_data[n0] !== 16'h0) begin
      miscompares++;
      $display("FAIL lone_pulses: got %0d issues expected 1 read", log_addr.size() - n0);
    end
    tick();
    i_rd = 1'b0;
    sample();
    vectors++;
    if ({i_stall, mem_rd, i_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL lone_idle: got %b expected 000", {i_stall, mem_rd, i_done});
    end
  endtask

  task automatic test_conflict();
    int n0, i_done_c;
    bit i_fin, d_fin;
    logic [15:0] e;
    do_reset();
    resp_lat = 1;
    n0 = log_addr.size();
    i_fin = 0; d_fin = 0; i_done_c = -100;
    tick();
    i_rd = 1'b1; i_addr = 16'h0200;
    d_wr = 1'b1; d_addr = 16'h0100; d_datain = 16'hBEEF;
    exp_q.push_back(16'h0200 ^ 16'hA5A5);
    exp_q.push_back(16'h0100 ^ 16'hA5A5);
    for (int k = 0; k < 40 && !d_fin; k++) begin
      sample();
      if (i_done) begin
        i_fin = 1; i_done_c = cyc;
        e = exp_q.pop_front();
        vectors++;
        if (i_dataout !== e) begin
          miscompares++;
          $display("FAIL conflict_i_data: got %h expected %h", i_dataout, e);
        end
      end
      if (d_done) begin
        d_fin = 1;
        e = exp_q.pop_front();
        vectors++;
        if (d_dataout !== e) begin
          miscompares++;
          $display("FAIL conflict_d_data: got %h expected %h", d_dataout, e);
        end
      end else begin
        vectors++;
        if (d_stall !== 1'b1) begin
          miscompares++;
          $display("FAIL conflict_d_stall: got %b expected 1", d_stall);
        end
      end
      if (i_fin && i_rd) begin
        tick();
        i_rd = 1'b0;
      end
    end
    tick();
    d_wr = 1'b0;
    vectors++;
    if (!d_fin || log_addr.size() != n0 + 2) begin
      miscompares++;
      $display("FAIL conflict_count: done %0d issues %0d expected 1 2", d_fin, log_addr.size() - n0);
    end else begin
      vectors++;
      if (log_addr[n0] !== 16'h0200 || log_wr[n0] !== 1'b0) begin
        miscompares++;
        $display("FAIL conflict_first: got %h wr %b expected 0200 wr 0", log_addr[n0], log_wr[n0]);
      end
      vectors++;
      if (log_addr[n0+1] !== 16'h0100 || log_wr[n0+1] !== 1'b1 || log_data[n0+1] !== 16'hBEEF) begin
        miscompares++;
        $display("FAIL conflict_store: got %h %h wr %b expected 0100 beef wr 1",
                 log_addr[n0+1], log_data[n0+1], log_wr[n0+1]);
      end
      vectors++;
      if (log_cyc[n0+1] != i_done_c + 2) begin
        miscompares++;
        $display("FAIL conflict_gap: got %0d expected %0d", log_cyc[n0+1], i_done_c + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0, count;
    logic [15:0] e;
    logic [15:0] exp_addr[4];
    exp_addr[0] = 16'h0300; exp_addr[1] = 16'h0400;
    exp_addr[2] = 16'h0300; exp_addr[3] = 16'h0400;
    resp_lat = 1;
    n0 = log_addr.size();
    count = 0;
    tick();
    i_rd = 1'b1; i_addr = 16'h0300;
    d_rd = 1'b1; d_addr = 16'h0400;
    for (int j = 0; j < 4; j++) exp_q.push_back(exp_addr[j] ^ 16'hA5A5);
    for (int k = 0; k < 60 && count < 4; k++) begin
      sample();
      if (i_done) begin
        count++;
        e = exp_q.pop_front();
        vectors++;
        if (i_dataout !== e) begin
          miscompares++;
          $display("FAIL b2b_i_data: got %h expected %h", i_dataout, e);
        end
      end
      if (d_done) begin
        count++;
        e = exp_q.pop_front();
        vectors++;
        if (d_dataout !== e) begin
          miscompares++;
          $display("FAIL b2b_d_data: got %h expected %h", d_dataout, e);
        end
      end
    end
    tick();
    i_rd = 1'b0; d_rd = 1'b0;
    sample();
    vectors++;
    if (count != 4 || log_addr.size() != n0 + 4) begin
      miscompares++;
      $display("FAIL b2b_count: done %0d issues %0d expected 4 4", count, log_addr.size() - n0);
    end else begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (log_addr[n0+j] !== exp_addr[j]) begin
          miscompares++;
          $display("FAIL b2b_order: grant %0d got %h expected %h", j, log_addr[n0+j], exp_addr[j]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n0, done_c;
    bit fin;
    logic [15:0] e;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pre_err: got %b expected 0", err);
    end
    resp_hang = 1'b1;
    n0 = log_addr.size();
    fin = 0; done_c = -1;
    tick();
    d_rd = 1'b1; d_addr = 16'h0500;
    exp_q.push_back(16'h0000);
    for (int k = 0; k < 120 && !fin; k++) begin
      sample();
      if (d_done) begin
        fin = 1; done_c = cyc;
        e = exp_q.pop_front();
        vectors++;
        if (d_dataout !== e) begin
          miscompares++;
          $display("FAIL timeout_data: got %h expected %h", d_dataout, e);
        end
      end
    end
    tick();
    d_rd = 1'b0;
    vectors++;
    if (!fin || log_addr.size() != n0 + 1) begin
      miscompares++;
      $display("FAIL timeout_done: done %0d issues %0d expected 1 1", fin, log_addr.size() - n0);
    end else begin
      vectors++;
      if (done_c - log_cyc[n0] != TIMEOUT + 1) begin
        miscompares++;
        $display("FAIL timeout_cycles: got %0d expected %0d", done_c - log_cyc[n0], TIMEOUT + 1);
      end
    end
    repeat (4) tick();
    sample();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err: got %b expected 1", err);
    end
    resp_hang = 1'b0;
  endtask

  task automatic test_illegal();
    int n0;
    do_reset();
    n0 = log_addr.size();
    tick();
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0900; d_datain = 16'h1111;
    sample();
    vectors++;
    if ({d_done, d_dataout, mem_rd, mem_wr, err} !== {1'b1, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL illegal_done: got %b %h %b%b%b expected 1 0000 000",
               d_done, d_dataout, mem_rd, mem_wr, err);
    end
    tick();
    d_rd = 1'b0; d_wr = 1'b0;
    repeat (3) sample();
    vectors++;
    if (err !== 1'b1 || log_addr.size() != n0) begin
      miscompares++;
      $display("FAIL illegal_err: err %b issues %0d expected 1 0", err, log_addr.size() - n0);
    end
  endtask

  task automatic test_mem_err();
    bit fin;
    logic [15:0] e;
    do_reset();
    resp_lat = 2;
    tick();
    mem_err = 1'b1;
    tick();
    mem_err = 1'b0;
    sample();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL mem_err_idle: got %b expected 0", err);
    end
    fin = 0;
    tick();
    i_rd = 1'b1; i_addr = 16'h0800; mem_err = 1'b1;
    exp_q.push_back(16'h0800 ^ 16'hA5A5);
    for (int k = 0; k < 20 && !fin; k++) begin
      sample();
      if (i_done) begin
        fin = 1;
        e = exp_q.pop_front();
        vectors++;
        if (i_dataout !== e) begin
          miscompares++;
          $display("FAIL mem_err_data: got %h expected %h", i_dataout, e);
        end
      end
    end
    tick();
    i_rd = 1'b0; mem_err = 1'b0;
    sample();
    vectors++;
    if (!fin || err !== 1'b1) begin
      miscompares++;
      $display("FAIL mem_err_sticky: done %0d err %b expected 1 1", fin, err);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    bit fin;
    logic [15:0] e;
    do_reset();
    resp_lat = 5;
    n0 = log_addr.size();
    tick();
    d_rd = 1'b1; d_addr = 16'h0600;
    for (int k = 0; k < 10 && log_addr.size() == n0; k++) sample();
    sample();
    sample();
    rst = 1'b1;
    #1;
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outs: got %h expected 0", all_outs);
    end
    d_rd = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20 && resp_busy; k++) begin
      sample();
      vectors++;
      if (i_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL late_done: i_done %b d_done %b err %b expected 000", i_done, d_done, err);
      end
    end
    resp_lat = 1;
    fin = 0;
    tick();
    i_rd = 1'b1; i_addr = 16'h0700;
    exp_q.push_back(16'h0700 ^ 16'hA5A5);
    for (int k = 0; k < 20 && !fin; k++) begin
      sample();
      if (i_done) begin
        fin = 1;
        e = exp_q.pop_front();
        vectors++;
        if (i_dataout !== e || mem_addr !== 16'h0700) begin
          miscompares++;
          $display("FAIL post_reset_fetch: got %h addr %h expected %h addr 0700", i_dataout, mem_addr, e);
        end
      end
    end
    tick();
    i_rd = 1'b0;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL post_reset_done: got 0 expected 1");
    end
  endtask

  initial begin
    rst = 1'b1;
    i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_err = 1'b0;
    i_addr = '0; d_addr = '0; d_datain = '0;
    test_reset();
    test_lone_fetch();
    test_conflict();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_mem_err();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
